// File: rtl/bsw_phase_ctrl.sv
// bsw_phase_ctrl: round-robin CK/CKB phase generator for an array of bootstrapped sampling switches.
// Outputs are registered from the sequencer state, so each phase appears one edge after the state enters it.
module bsw_phase_ctrl #(
    parameter int NCH     = 4,
    parameter int TRACK_W = 4,
    parameter int GAP_W   = 2
) (
    input  logic                   ck_i,
    input  logic                   rstb_i,
    input  logic                   en_i,
    input  logic                   mode_i,
    input  logic                   start_i,
    input  logic [NCH-1:0]         ch_mask_i,
    input  logic [TRACK_W-1:0]     track_cyc_i,
    input  logic [GAP_W-1:0]       gap_cyc_i,
    output logic [NCH-1:0]         cks_o,
    output logic [NCH-1:0]         ckbs_o,
    output logic [$clog2(NCH)-1:0] ch_idx_o,
    output logic                   busy_o,
    output logic                   sample_done_o,
    output logic [$clog2(NCH)-1:0] done_ch_o
);
    localparam int CHW = $clog2(NCH);
    localparam int CW  = (TRACK_W > GAP_W) ? TRACK_W : GAP_W;

    typedef enum logic [1:0] {IDLE, GAP1, TRACK, GAP2} state_e;

    state_e             state_q, state_d;
    logic [CHW-1:0]     ch_q, ch_d, first_q, first_d, nxt;
    logic               mode_q, mode_d;
    logic [TRACK_W-1:0] trk_q, trk_d, t_eff;
    logic [GAP_W-1:0]   gap_q, gap_d, g_eff;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NCH-1:0]     cks_q, cks_d, ckbs_q, ckbs_d, onehot;
    logic [CHW-1:0]     ch_idx_q, ch_idx_d, done_ch_q, done_ch_d;
    logic               busy_q, busy_d, done_q, done_d, last, launch;

    // First set bit of m strictly after c, wrapping; returns c itself when it is the only set bit.
    function automatic logic [CHW-1:0] next_set(input logic [NCH-1:0] m, input logic [CHW-1:0] c);
        logic [CHW-1:0] idx;
        next_set = c;
        for (int k = NCH; k >= 1; k--) begin
            idx = CHW'((int'(c) + k) % NCH);
            if (m[idx]) next_set = idx;
        end
    endfunction

    assign g_eff  = (gap_cyc_i == '0) ? GAP_W'(1) : gap_cyc_i;
    assign t_eff  = (track_cyc_i == '0) ? TRACK_W'(1) : track_cyc_i;
    assign last   = (cnt_q == '0);
    assign nxt    = next_set(ch_mask_i, (state_q == IDLE) ? CHW'(NCH - 1) : ch_q);
    // A pass in single-shot mode ends once the search wraps back to or below its first channel.
    assign launch = (|ch_mask_i) && ((state_q == IDLE) ? (mode_i ? start_i : en_i)
                  : (state_q == GAP2 && last && (mode_q ? (nxt > first_q) : en_i)));
    assign onehot = NCH'(1) << ch_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        first_d = first_q;
        mode_d  = mode_q;
        trk_d   = trk_q;
        gap_d   = gap_q;
        cnt_d   = (state_q == IDLE) ? cnt_q : cnt_q - CW'(1);
        case (state_q)
            GAP1:    if (last) begin state_d = TRACK; cnt_d = CW'(trk_q) - CW'(1); end
            TRACK:   if (last) begin state_d = GAP2;  cnt_d = CW'(gap_q) - CW'(1); end
            GAP2:    if (last) state_d = IDLE;
            default: ;
        endcase
        if (launch) begin
            state_d = GAP1;
            ch_d    = nxt;
            trk_d   = t_eff;
            gap_d   = g_eff;
            cnt_d   = CW'(g_eff) - CW'(1);
            if (state_q == IDLE) begin
                first_d = nxt;
                mode_d  = mode_i;
            end
        end
    end

    assign cks_d     = (state_q == TRACK) ? onehot : '0;
    assign ckbs_d    = (state_q == IDLE) ? '1 : ~onehot;
    assign busy_d    = (state_q != IDLE);
    assign done_d    = (state_q == GAP2) && (cnt_q == CW'(gap_q) - CW'(1));
    assign done_ch_d = done_d ? ch_q : done_ch_q;
    assign ch_idx_d  = ch_q;

    always_ff @(posedge ck_i) begin
        if (!rstb_i) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            first_q   <= '0;
            mode_q    <= 1'b0;
            trk_q     <= TRACK_W'(1);
            gap_q     <= GAP_W'(1);
            cnt_q     <= '0;
            cks_q     <= '0;
            ckbs_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_ch_q <= '0;
            ch_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            first_q   <= first_d;
            mode_q    <= mode_d;
            trk_q     <= trk_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            cks_q     <= cks_d;
            ckbs_q    <= ckbs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_ch_q <= done_ch_d;
            ch_idx_q  <= ch_idx_d;
        end
    end

    assign cks_o         = cks_q;
    assign ckbs_o        = ckbs_q;
    assign ch_idx_o      = ch_idx_q;
    assign busy_o        = busy_q;
    assign sample_done_o = done_q;
    assign done_ch_o     = done_ch_q;
endmodule

// File: tb/tb_bsw_phase_ctrl.sv
// tb_bsw_phase_ctrl: directed bench with a schedule-based reference model checked every cycle.
module tb_bsw_phase_ctrl;
    localparam int NCH = 4;
    localparam int TW  = 4;
    localparam int GW  = 2;
    localparam int CHW = $clog2(NCH);

    logic clk = 1'b0, rstb = 1'b0, en = 1'b0, mode = 1'b0, start = 1'b0;
    logic [NCH-1:0] mask = 4'b1111;
    logic [TW-1:0]  trk = 4'd3;
    logic [GW-1:0]  gap = 2'd1;
    logic [NCH-1:0] cks, ckbs;
    logic [CHW-1:0] idx, dch;
    logic           busy, sdone;

    int n_cmp = 0, n_fail = 0, e = 0, nd = 0, ds[2];
    bit bad = 0;

    always #5 clk = ~clk;

    bsw_phase_ctrl #(.NCH(NCH), .TRACK_W(TW), .GAP_W(GW)) dut (
        .ck_i(clk), .rstb_i(rstb), .en_i(en), .mode_i(mode), .start_i(start),
        .ch_mask_i(mask), .track_cyc_i(trk), .gap_cyc_i(gap),
        .cks_o(cks), .ckbs_o(ckbs), .ch_idx_o(idx), .busy_o(busy),
        .sample_done_o(sdone), .done_ch_o(dch)
    );

    typedef struct {
        logic [NCH-1:0] cks;
        logic [NCH-1:0] ckbs;
        logic           busy;
        logic           done;
        int             ch;
    } vec_t;

    vec_t q[$];
    vec_t ex;
    bit   mval = 0, act = 0, rst_seen = 0, m_mode = 0;
    int   m_first = 0, m_ch = 0;

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] b);
        n_cmp++;
        if (a !== b) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, b, $time);
        end
    endtask

    function automatic int nxt(input logic [NCH-1:0] m, input int c);
        logic [CHW-1:0] k2;
        for (int k = 1; k <= NCH; k++) begin
            k2 = CHW'((c + k) % NCH);
            if (m[k2]) return int'(k2);
        end
        return c;
    endfunction

    // Queue the full output schedule of one channel: G gap, T track, G gap.
    task automatic plan(input int c);
        int t, g;
        vec_t v;
        logic [NCH-1:0] oh;
        t = (trk == 0) ? 1 : int'(trk);
        g = (gap == 0) ? 1 : int'(gap);
        oh = '0;
        oh[CHW'(c)] = 1'b1;
        for (int i = 0; i < 2 * g + t; i++) begin
            v.cks  = (i >= g && i < g + t) ? oh : '0;
            v.ckbs = ~oh;
            v.busy = 1'b1;
            v.done = (i == g + t);
            v.ch   = c;
            q.push_back(v);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rstb) begin
            q.delete();
            act = 0;
            rst_seen = 1;
            ex = '{cks: '0, ckbs: '1, busy: 1'b0, done: 1'b0, ch: 0};
        end else begin
            rst_seen = 0;
            if (q.size() > 0) ex = q.pop_front();
            else begin
                ex.cks = '0; ex.ckbs = '1; ex.busy = 1'b0; ex.done = 1'b0;
            end
            if (q.size() == 0) begin
                if (act) begin
                    int n;
                    n = nxt(mask, m_ch);
                    if (mask != 0 && (m_mode ? (n > m_first) : en)) begin
                        m_ch = n;
                        plan(n);
                    end else act = 0;
                end else if (mask != 0 && (mode ? start : en)) begin
                    m_ch = nxt(mask, NCH - 1);
                    m_first = m_ch;
                    m_mode = mode;
                    act = 1;
                    plan(m_ch);
                end
            end
        end
        mval = 1;
    end

    initial forever begin
        @(negedge clk);
        if (mval) begin
            cmp("cks", cks, ex.cks);
            cmp("ckbs", ckbs, ex.ckbs);
            cmp("busy", busy, ex.busy);
            cmp("sample_done", sdone, ex.done);
            if (ex.busy || rst_seen) cmp("ch_idx", idx, ex.ch);
            if (ex.done) cmp("done_ch", dch, ex.ch);
            cmp("inv_overlap", |(cks & ckbs), 0);
            cmp("inv_cks_onehot", $countones(cks) <= 1, 1);
            cmp("inv_ckbs_onelow", $countones(~ckbs) <= 1, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic go(input int t);
        while (e < t) tick();
    endtask

    task automatic launch();
        e = -1;
        tick();
    endtask

    task automatic wait_idle();
        en = 0;
        start = 0;
        for (int i = 0; i < 60 && busy; i++) tick();
        cmp("idle_timeout", busy, 0);
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        cmp("rst_cks", cks, 4'b0000);
        cmp("rst_ckbs", ckbs, 4'b1111);
        cmp("rst_busy", busy, 0);
        cmp("rst_idx", idx, 0);
        cmp("rst_done", sdone, 0);
        rstb = 1;
        tick();

        en = 1;
        launch();
        go(1);  cmp("c_e1_ckbs", ckbs, 4'b1110); cmp("c_e1_cks", cks, 4'b0000);
        go(2);  cmp("c_e2_cks", cks, 4'b0001);
        go(4);  cmp("c_e4_cks", cks, 4'b0001);
        go(5);  cmp("c_e5_done", sdone, 1); cmp("c_e5_dch", dch, 0); cmp("c_e5_cks", cks, 4'b0000);
        go(6);  cmp("c_e6_ckbs", ckbs, 4'b1101); cmp("c_e6_cks", cks, 4'b0000);
        go(21); cmp("c_e21_ckbs", ckbs, 4'b1110);
        go(100);
        wait_idle();
        cmp("c_idle_ckbs", ckbs, 4'b1111);

        en = 1;
        launch();
        go(12); cmp("ab_e12_cks", cks, 4'b0100);
        en = 0;
        go(14); cmp("ab_e14_cks", cks, 4'b0100);
        go(15); cmp("ab_e15_done", sdone, 1); cmp("ab_e15_dch", dch, 2);
        go(16); cmp("ab_e16_ckbs", ckbs, 4'b1111); cmp("ab_e16_busy", busy, 0);
        wait_idle();

        mode = 1; mask = 4'b1010; trk = 4'd2; gap = 2'd1; start = 1;
        launch();
        start = 0;
        nd = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (e == 3) start = 1;
            if (e == 4) start = 0;
            if (e == 5) mode = 0;
            if (sdone) begin
                if (nd < 2) ds[nd] = int'(dch);
                nd++;
            end
            if (cks[0] | cks[2] | !ckbs[0] | !ckbs[2]) bad = 1;
        end
        cmp("ss_count", nd, 2);
        cmp("ss_first", ds[0], 1);
        cmp("ss_second", ds[1], 3);
        cmp("ss_busy", busy, 0);
        cmp("ss_unselected", bad, 0);
        cmp("ss_ckbs", ckbs, 4'b1111);
        wait_idle();

        mode = 0; mask = 4'b1111; trk = 4'd0; gap = 2'd0; en = 1;
        launch();
        go(1); cmp("z_e1_ckbs", ckbs, 4'b1110); cmp("z_e1_cks", cks, 4'b0000);
        go(2); cmp("z_e2_cks", cks, 4'b0001);
        go(3); cmp("z_e3_done", sdone, 1); cmp("z_e3_cks", cks, 4'b0000);
        go(4); cmp("z_e4_ckbs", ckbs, 4'b1101);
        go(7); cmp("z_e7_ckbs", ckbs, 4'b1011);
        wait_idle();

        trk = 4'd3; gap = 2'd1; en = 1;
        launch();
        go(2);  cmp("m_e2_cks", cks, 4'b0001);
        trk = 4'd6;
        go(4);  cmp("m_e4_cks", cks, 4'b0001);
        go(5);  cmp("m_e5_cks", cks, 4'b0000); cmp("m_e5_done", sdone, 1);
        go(7);  cmp("m_e7_cks", cks, 4'b0010);
        go(8);  mask = 4'b0001;
        go(12); cmp("m_e12_cks", cks, 4'b0010);
        go(13); cmp("m_e13_cks", cks, 4'b0000); cmp("m_e13_dch", dch, 1);
        go(14); cmp("m_e14_ckbs", ckbs, 4'b1110);
        wait_idle();
        mask = 4'b1111;

        trk = 4'd3; en = 1;
        launch();
        go(3); cmp("r_e3_cks", cks, 4'b0001);
        rstb = 0;
        go(4);
        cmp("r_cks", cks, 4'b0000);
        cmp("r_ckbs", ckbs, 4'b1111);
        cmp("r_busy", busy, 0);
        cmp("r_idx", idx, 0);
        cmp("r_done", sdone, 0);
        en = 0;
        go(5);
        rstb = 1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
